// File: rtl/rv32i_types_pkg.sv
// Shared RV32I datapath types used by the execute, writeback and register file blocks.
package rv32i_types_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_MAX_SRC = 8;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // One pending register write: destination register plus the value to store.
    typedef struct packed {
        logic [4:0] rd;
        word_t      data;
    } wb_req_t;

    // x0 is hardwired to zero, so a write aimed at it carries no information.
    function automatic logic is_x0(input reg_addr_t rd);
        return (rd == '0);
    endfunction

endpackage

// File: rtl/rv32i_writeback_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant, and it owns its own rotating priority pointer.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Grant the first requester found when searching upward from the pointer, wrapping at N.
    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_d    = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    // Pointer moves just past the winner so it becomes the lowest priority next cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rv32i_writeback_arbiter.sv
// Writeback arbiter: buffers one result per functional unit and retires one
// register write per cycle into the register file write port.
module rv32i_writeback_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int NUM_SRC = 3
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC-1:0][4:0]      src_rd,
    input  word_t [NUM_SRC-1:0]          src_data,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic                         wb_wen,
    output logic [4:0]                   wb_rd,
    output word_t                        wb_w_data,
    output logic [NUM_SRC-1:0]           wb_grant
);

    wb_req_t            buf_q [NUM_SRC];
    logic [NUM_SRC-1:0] occ_q;
    logic [NUM_SRC-1:0] gnt;
    logic [NUM_SRC-1:0] xfer;

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_rr_arbiter (
        .CLK  (CLK),
        .nRST (nRST),
        .req  (occ_q),
        .gnt  (gnt)
    );

    // A buffer can take a new result when empty or when its current entry is retiring now;
    // ready comes from registered state only, so producers never see a loop through valid.
    assign src_ready = ~occ_q | gnt;
    assign xfer      = src_valid & src_ready;
    assign wb_grant  = gnt;
    assign wb_wen    = |gnt;

    // Holding buffers: fill on a transfer (x0 results are dropped), drain on grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            occ_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (xfer[i] && !is_x0(src_rd[i])) begin
                    occ_q[i]      <= 1'b1;
                    buf_q[i].rd   <= src_rd[i];
                    buf_q[i].data <= src_data[i];
                end else if (gnt[i]) begin
                    occ_q[i] <= 1'b0;
                end
            end
        end
    end

    // One-hot AND-OR mux of the granted buffer; all zero when nothing is granted.
    always_comb begin
        wb_rd     = '0;
        wb_w_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            wb_rd     = wb_rd     | (buf_q[i].rd   & {5{gnt[i]}});
            wb_w_data = wb_w_data | (buf_q[i].data & {32{gnt[i]}});
        end
    end

endmodule

// File: tb/tb_rv32i_writeback_arbiter.sv
// Self-checking bench for rv32i_writeback_arbiter with a queue-level reference model.
module tb_rv32i_writeback_arbiter;

    localparam int NS = 3;

    logic                CLK;
    logic                nRST;
    logic [NS-1:0]       src_valid;
    logic [NS-1:0][4:0]  src_rd;
    logic [NS-1:0][31:0] src_data;
    logic [NS-1:0]       src_ready;
    logic                wb_wen;
    logic [4:0]          wb_rd;
    logic [31:0]         wb_w_data;
    logic [NS-1:0]       wb_grant;

    int errors = 0;
    int checks = 0;

    // Reference model: each source holds a queue of at most one pending write.
    logic [36:0] m_pend [NS][$];
    int          m_ptr;
    logic [NS-1:0] last_acc;

    logic [43:0] obs;
    logic [43:0] exp_v;

    rv32i_writeback_arbiter #(.NUM_SRC(NS)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .src_valid (src_valid),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .src_ready (src_ready),
        .wb_wen    (wb_wen),
        .wb_rd     (wb_rd),
        .wb_w_data (wb_w_data),
        .wb_grant  (wb_grant)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int model_winner();
        for (int k = 0; k < NS; k++) begin
            int j;
            j = (m_ptr + k) % NS;
            if (m_pend[j].size() != 0) return j;
        end
        return -1;
    endfunction

    function automatic logic [43:0] model_vec();
        int          g;
        logic [36:0] e;
        logic [2:0]  gv;
        logic [2:0]  rv;
        g  = model_winner();
        gv = '0;
        rv = '0;
        e  = '0;
        if (g >= 0) begin
            e     = m_pend[g][0];
            gv[g] = 1'b1;
        end
        for (int i = 0; i < NS; i++) rv[i] = (m_pend[i].size() == 0) || (i == g);
        return {(g >= 0), e, gv, rv};
    endfunction

    function automatic logic [43:0] dut_vec();
        return {wb_wen, wb_rd, wb_w_data, wb_grant, src_ready};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_pend[i].delete();
        m_ptr = 0;
    endtask

    // Clock one edge, then apply the retire/accept rules to the model.
    task automatic advance();
        int            g;
        logic [43:0]   v;
        logic [NS-1:0] acc;
        logic [NS-1:0][4:0]  rd_s;
        logic [NS-1:0][31:0] d_s;
        g    = model_winner();
        v    = model_vec();
        acc  = src_valid & v[2:0];
        rd_s = src_rd;
        d_s  = src_data;
        @(posedge CLK);
        #1;
        if (g >= 0) begin
            void'(m_pend[g].pop_front());
            m_ptr = (g + 1) % NS;
        end
        for (int i = 0; i < NS; i++) begin
            if (acc[i] && rd_s[i] != 5'd0) m_pend[i].push_back({rd_s[i], d_s[i]});
        end
        last_acc = acc;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        src_valid = '0; src_rd = '0; src_data = '0;
        model_reset();
        #12;
        exp_v = model_vec(); obs = dut_vec(); checks++;
        if (obs !== exp_v) begin errors++; $display("[TB] FAIL reset: got %h expected %h", obs, exp_v); end
        nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_contention();
        src_valid = 3'b111;
        src_rd    = {5'd3, 5'd2, 5'd1};
        src_data  = {32'hA3, 32'hA2, 32'hA1};
        advance();
        src_valid = '0;
        for (int c = 0; c < 4; c++) begin
            exp_v = model_vec(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin errors++; $display("[TB] FAIL contention cyc%0d: got %h expected %h", c, obs, exp_v); end
            if (c < 3) begin
                checks++;
                if (wb_wen !== 1'b1 || wb_rd !== 5'(c + 1)) begin
                    errors++; $display("[TB] FAIL contention_order cyc%0d: got wen=%b rd=%0d expected wen=1 rd=%0d", c, wb_wen, wb_rd, c + 1);
                end
            end
            advance();
        end
    endtask

    task automatic test_single();
        src_valid = 3'b001; src_rd[0] = 5'd5; src_data[0] = 32'hDEADBEEF;
        advance();
        src_valid = '0;
        checks++;
        if ({wb_wen, wb_rd, wb_w_data, wb_grant} !== {1'b1, 5'd5, 32'hDEADBEEF, 3'b001}) begin
            errors++; $display("[TB] FAIL single_write: got %b %0d %h %b expected 1 5 deadbeef 001", wb_wen, wb_rd, wb_w_data, wb_grant);
        end
        for (int c = 0; c < 2; c++) begin
            exp_v = model_vec(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin errors++; $display("[TB] FAIL single cyc%0d: got %h expected %h", c, obs, exp_v); end
            advance();
        end
    endtask

    task automatic test_x0_discard();
        src_valid = 3'b010; src_rd[1] = 5'd0; src_data[1] = 32'h1234;
        checks++;
        if (src_ready[1] !== 1'b1) begin errors++; $display("[TB] FAIL x0_ready: got %b expected 1", src_ready[1]); end
        advance();
        src_valid = '0;
        for (int c = 0; c < 3; c++) begin
            exp_v = model_vec(); obs = dut_vec(); checks++;
            if (obs !== exp_v || wb_wen !== 1'b0) begin errors++; $display("[TB] FAIL x0 cyc%0d: got %h expected %h", c, obs, exp_v); end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        src_rd[2] = 5'd7;
        for (int n = 0; n < 8; n++) begin
            src_valid = 3'b100; src_data[2] = 32'h10 + 32'(n);
            exp_v = model_vec(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin errors++; $display("[TB] FAIL b2b cyc%0d: got %h expected %h", n, obs, exp_v); end
            if (n > 0) begin
                checks++;
                if (src_ready[2] !== 1'b1 || wb_wen !== 1'b1 || wb_w_data !== 32'h10 + 32'(n - 1)) begin
                    errors++; $display("[TB] FAIL b2b_stream cyc%0d: got rdy=%b wen=%b data=%h expected 1 1 %h", n, src_ready[2], wb_wen, wb_w_data, 32'h10 + 32'(n - 1));
                end
            end
            advance();
        end
        src_valid = '0;
        advance();
        advance();
    endtask

    task automatic test_backpressure();
        int sent0 = 0;
        int sent1 = 0;
        src_valid = 3'b011;
        src_rd[0] = 5'd11; src_data[0] = 32'hB000;
        src_rd[1] = 5'd12; src_data[1] = 32'hC000;
        for (int c = 0; c < 12; c++) begin
            exp_v = model_vec(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin errors++; $display("[TB] FAIL backpressure cyc%0d: got %h expected %h", c, obs, exp_v); end
            advance();
            if (last_acc[0]) begin sent0++; src_data[0] = 32'hB000 + 32'(sent0); end
            if (last_acc[1]) begin sent1++; src_data[1] = 32'hC000 + 32'(sent1); end
        end
        src_valid = '0;
        for (int c = 0; c < 3; c++) begin
            exp_v = model_vec(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin errors++; $display("[TB] FAIL backpressure_drain cyc%0d: got %h expected %h", c, obs, exp_v); end
            advance();
        end
    endtask

    task automatic test_mid_reset();
        src_valid = 3'b011;
        src_rd[0] = 5'd9;  src_data[0] = 32'h9999;
        src_rd[1] = 5'd10; src_data[1] = 32'hAAAA;
        advance();
        src_valid = '0;
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        checks++;
        if (wb_wen !== 1'b0 || src_ready !== 3'b111 || wb_grant !== 3'b000 || wb_rd !== 5'd0 || wb_w_data !== 32'd0) begin
            errors++; $display("[TB] FAIL mid_reset: got wen=%b rdy=%b gnt=%b rd=%0d data=%h expected 0 111 000 0 0", wb_wen, src_ready, wb_grant, wb_rd, wb_w_data);
        end
        @(negedge CLK);
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            exp_v = model_vec(); obs = dut_vec(); checks++;
            if (obs !== exp_v || wb_wen !== 1'b0) begin errors++; $display("[TB] FAIL post_reset cyc%0d: got %h expected %h", c, obs, exp_v); end
            advance();
        end
    endtask

    task automatic test_random();
        last_acc = '1;
        src_valid = '0;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < NS; i++) begin
                if (!(src_valid[i] && !last_acc[i])) begin
                    src_valid[i] = ($urandom_range(0, 3) != 0);
                    src_rd[i]    = 5'($urandom_range(0, 31));
                    src_data[i]  = $urandom;
                end
            end
            exp_v = model_vec(); obs = dut_vec(); checks++;
            if (obs !== exp_v) begin errors++; $display("[TB] FAIL random cyc%0d: got %h expected %h", c, obs, exp_v); end
            advance();
        end
        src_valid = '0;
    endtask

    initial begin
        last_acc = '0;
        test_reset();
        test_contention();
        test_single();
        test_x0_discard();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
